// File: rtl/peri_timer.sv
// Memory-mapped 8-bit timer peripheral: prescaled up-counter with one-shot or
// auto-reload overflow, sticky overflow flag and a registered interrupt request.
module peri_timer #(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk_ip,
  input  logic       reset_n_ip,
  input  logic [7:0] addr_ip,
  input  logic [7:0] data_ip,
  input  logic       wr_en_ip,
  input  logic       rd_en_ip,
  output logic [7:0] data_op,
  output logic       irq_op
);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_FLAG   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RELOAD = 2'd3;

  logic [7:0] offset;
  logic       hit;
  logic [1:0] reg_sel;
  logic       wr_ctrl;
  logic       wr_flag;
  logic       wr_count;
  logic       wr_reload;

  logic       en;
  logic       arl;
  logic       ie;
  logic [1:0] ps;
  logic       ovf;
  logic [7:0] count;
  logic [7:0] reload;
  logic [5:0] presc;

  logic       tick;
  logic       ovf_evt;
  logic [7:0] ctrl_val;

  // Address decode: the block owns BASE_ADDR..BASE_ADDR+3.
  assign offset    = addr_ip - BASE_ADDR;
  assign hit       = (offset[7:2] == 6'd0);
  assign reg_sel   = offset[1:0];
  assign wr_ctrl   = wr_en_ip && hit && (reg_sel == OFF_CTRL);
  assign wr_flag   = wr_en_ip && hit && (reg_sel == OFF_FLAG);
  assign wr_count  = wr_en_ip && hit && (reg_sel == OFF_COUNT);
  assign wr_reload = wr_en_ip && hit && (reg_sel == OFF_RELOAD);

  assign ctrl_val  = {2'b00, ps, 1'b0, ie, arl, en};

  always_comb begin
    tick = 1'b0;
    case (ps)
      2'b00:   tick = en;
      2'b01:   tick = en && (&presc[1:0]);
      2'b10:   tick = en && (&presc[3:0]);
      default: tick = en && (&presc);
    endcase
  end

  // A CPU write to COUNT overrides the tick entirely, so it also masks overflow.
  assign ovf_evt = tick && (count == 8'hFF) && !wr_count;

  always_ff @(posedge clk_ip) begin
    if (!reset_n_ip) begin
      en  <= 1'b0;
      arl <= 1'b0;
      ie  <= 1'b0;
      ps  <= 2'b00;
    end else if (wr_ctrl) begin
      en  <= data_ip[0];
      arl <= data_ip[1];
      ie  <= data_ip[2];
      ps  <= data_ip[5:4];
    end else if (ovf_evt && !arl) begin
      en  <= 1'b0;
    end
  end

  always_ff @(posedge clk_ip) begin
    if (!reset_n_ip || wr_ctrl || !en) begin
      presc <= 6'd0;
    end else begin
      presc <= presc + 6'd1;
    end
  end

  always_ff @(posedge clk_ip) begin
    if (!reset_n_ip) begin
      count <= 8'h00;
    end else if (wr_count) begin
      count <= data_ip;
    end else if (ovf_evt) begin
      count <= arl ? reload : 8'h00;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  always_ff @(posedge clk_ip) begin
    if (!reset_n_ip) begin
      reload <= 8'h00;
    end else if (wr_reload) begin
      reload <= data_ip;
    end
  end

  // Overflow set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk_ip) begin
    if (!reset_n_ip) begin
      ovf    <= 1'b0;
      irq_op <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf <= 1'b1;
      end else if (wr_flag && data_ip[0]) begin
        ovf <= 1'b0;
      end
      irq_op <= ovf && ie;
    end
  end

  // Every register resets to zero, so gating with reset yields the reset values.
  always_comb begin
    data_op = 8'h00;
    if (rd_en_ip && hit && reset_n_ip) begin
      case (reg_sel)
        OFF_CTRL:  data_op = ctrl_val;
        OFF_FLAG:  data_op = {7'b0, ovf};
        OFF_COUNT: data_op = count;
        default:   data_op = reload;
      endcase
    end
  end

endmodule

// File: tb/tb_peri_timer.sv
// Directed bench for peri_timer: bus tasks queue expected read data / irq,
// a negedge monitor pops and compares whenever a read (or probe) is presented.
module tb_peri_timer;

  logic       clk_ip = 1'b0;
  logic       reset_n_ip = 1'b0;
  logic [7:0] addr_ip = 8'h00;
  logic [7:0] data_ip = 8'h00;
  logic       wr_en_ip = 1'b0;
  logic       rd_en_ip = 1'b0;
  logic [7:0] data_op;
  logic       irq_op;
  logic       probe = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_data_q[$];
  int         exp_irq_q[$];
  string      exp_name_q[$];

  peri_timer #(.BASE_ADDR(8'h10)) dut (
    .clk_ip     (clk_ip),
    .reset_n_ip (reset_n_ip),
    .addr_ip    (addr_ip),
    .data_ip    (data_ip),
    .wr_en_ip   (wr_en_ip),
    .rd_en_ip   (rd_en_ip),
    .data_op    (data_op),
    .irq_op     (irq_op)
  );

  always #5 clk_ip = ~clk_ip;

  // Monitor
  always @(negedge clk_ip) begin
    if (rd_en_ip || probe) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read addr=%02h data=%02h required=no-read", addr_ip, data_op);
      end else begin
        logic [7:0] ed;
        int         ei;
        string      nm;
        ed = exp_data_q.pop_front();
        ei = exp_irq_q.pop_front();
        nm = exp_name_q.pop_front();
        checks++;
        if (data_op !== ed) begin
          failures++;
          $display("FAIL %s data actual=%02h required=%02h", nm, data_op, ed);
        end
        if (ei >= 0) begin
          checks++;
          if (irq_op !== ei[0]) begin
            failures++;
            $display("FAIL %s irq actual=%b required=%0d", nm, irq_op, ei);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_ip);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr_ip = a; data_ip = d; wr_en_ip = 1'b1;
    step();
    wr_en_ip = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input int exp_irq, input string nm);
    exp_data_q.push_back(exp);
    exp_irq_q.push_back(exp_irq);
    exp_name_q.push_back(nm);
    addr_ip = a; rd_en_ip = 1'b1;
    step();
    rd_en_ip = 1'b0;
  endtask

  task automatic wrrd(input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp, input string nm);
    exp_data_q.push_back(exp);
    exp_irq_q.push_back(-1);
    exp_name_q.push_back(nm);
    addr_ip = a; data_ip = d; wr_en_ip = 1'b1; rd_en_ip = 1'b1;
    step();
    wr_en_ip = 1'b0; rd_en_ip = 1'b0;
  endtask

  task automatic probe_idle(input logic [7:0] a, input string nm);
    exp_data_q.push_back(8'h00);
    exp_irq_q.push_back(-1);
    exp_name_q.push_back(nm);
    addr_ip = a; probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    reset_n_ip = 1'b0;
    idle(2);
    rd(8'h10, 8'h00, -1, "ctrl_in_reset");
    reset_n_ip = 1'b1;
    rd(8'h10, 8'h00, 0, "rst_ctrl");
    rd(8'h11, 8'h00, 0, "rst_flag");
    rd(8'h12, 8'h00, -1, "rst_count");
    rd(8'h13, 8'h00, -1, "rst_reload");

    // Decode, isolation, simultaneous read/write
    wr(8'h13, 8'h5A);
    wr(8'h12, 8'hA5);
    wr(8'h0F, 8'hFF);
    wr(8'h14, 8'hFF);
    rd(8'h0F, 8'h00, -1, "rd_below_base");
    rd(8'h14, 8'h00, -1, "rd_above_top");
    probe_idle(8'h12, "no_rd_en");
    rd(8'h10, 8'h00, -1, "iso_ctrl");
    rd(8'h11, 8'h00, -1, "iso_flag");
    rd(8'h12, 8'hA5, -1, "iso_count");
    rd(8'h13, 8'h5A, -1, "iso_reload");
    wrrd(8'h12, 8'h77, 8'hA5, "wrrd_old");
    rd(8'h12, 8'h77, -1, "wrrd_new");

    // One-shot /1 with IE
    wr(8'h12, 8'hFD);
    wr(8'h10, 8'h05);
    rd(8'h12, 8'hFD, -1, "os_cnt_fd");
    rd(8'h12, 8'hFE, -1, "os_cnt_fe");
    rd(8'h12, 8'hFF, -1, "os_cnt_ff");
    rd(8'h11, 8'h01, 0, "os_flag_set");
    rd(8'h10, 8'h04, 1, "os_ctrl_en_clr");
    rd(8'h12, 8'h00, 1, "os_cnt_stop");
    wr(8'h11, 8'h00);
    rd(8'h11, 8'h01, 1, "flag_wr0_noeffect");

    // Overflow colliding with FLAG clear, then a plain clear
    wr(8'h12, 8'hFE);
    wr(8'h10, 8'h05);
    idle(1);
    wr(8'h11, 8'h01);
    rd(8'h11, 8'h01, 1, "clr_set_collide");
    wr(8'h11, 8'h01);
    rd(8'h11, 8'h00, 1, "clr_flag");
    rd(8'h11, 8'h00, 0, "clr_irq_fall");

    // COUNT write on the overflow edge
    wr(8'h12, 8'hFE);
    wr(8'h10, 8'h01);
    idle(1);
    wr(8'h12, 8'h10);
    rd(8'h12, 8'h10, -1, "tick_wr_count");
    rd(8'h11, 8'h00, -1, "tick_wr_no_ovf");
    rd(8'h10, 8'h01, -1, "tick_wr_en_kept");
    wr(8'h10, 8'h00);

    // CTRL write on a one-shot overflow edge
    wr(8'h12, 8'hFE);
    wr(8'h10, 8'h01);
    idle(1);
    wr(8'h10, 8'h01);
    rd(8'h10, 8'h01, -1, "ctrl_wr_en_wins");
    rd(8'h11, 8'h01, 0, "ctrl_wr_ovf");
    wr(8'h10, 8'h00);
    wr(8'h11, 8'h01);
    rd(8'h11, 8'h00, -1, "ctrl_wr_clr");

    // Auto-reload /4
    wr(8'h13, 8'hF0);
    rd(8'h13, 8'hF0, -1, "arl_reload");
    wr(8'h12, 8'hFF);
    wr(8'h10, 8'h13);
    rd(8'h12, 8'hFF, -1, "arl_presc0");
    rd(8'h12, 8'hFF, -1, "arl_presc1");
    rd(8'h12, 8'hFF, -1, "arl_presc2");
    rd(8'h11, 8'h00, -1, "arl_presc3");
    rd(8'h12, 8'hF0, -1, "arl_reloaded");
    rd(8'h11, 8'h01, 0, "arl_flag");
    wr(8'h11, 8'h01);
    idle(59);
    rd(8'h11, 8'h00, 0, "arl_no_early_ovf");
    rd(8'h12, 8'hFF, -1, "arl_cnt_ff");
    rd(8'h12, 8'hF0, -1, "arl_second_ovf");
    rd(8'h11, 8'h01, 0, "arl_flag2");
    idle(61);
    wr(8'h13, 8'h33);
    rd(8'h12, 8'hF0, -1, "reload_old_value");
    rd(8'h13, 8'h33, -1, "reload_new");
    rd(8'h10, 8'h13, -1, "arl_ctrl");

    // Reset during /64 counting with OVF and IE set
    wr(8'h10, 8'h37);
    rd(8'h10, 8'h37, 0, "pre_rst_ctrl");
    rd(8'h11, 8'h01, 1, "pre_rst_irq");
    reset_n_ip = 1'b0;
    rd(8'h10, 8'h00, -1, "rd_during_reset");
    reset_n_ip = 1'b1;
    rd(8'h10, 8'h00, 0, "mid_rst_ctrl");
    rd(8'h11, 8'h00, 0, "mid_rst_flag");
    rd(8'h12, 8'h00, -1, "mid_rst_count");
    rd(8'h13, 8'h00, -1, "mid_rst_reload");
    idle(70);
    rd(8'h12, 8'h00, -1, "no_resume_count");
    rd(8'h11, 8'h00, 0, "no_resume_flag");

    @(negedge clk_ip);
    checks++;
    if (exp_data_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_data_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peri_timer.md
PERI_TIMER -- requirements
Module: peri_timer

Interface
REQ-001 Parameter BASE_ADDR, default 8'h10, sets the peripheral-bus address of register 0 (CTRL); registers occupy BASE_ADDR..BASE_ADDR+3.
REQ-002 clk_ip  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n_ip  input  1  reset, synchronous and active-low.
REQ-004 addr_ip  input  8  peripheral-bus address from the CPU.
REQ-005 data_ip  input  8  peripheral-bus write data from the CPU (W register).
REQ-006 wr_en_ip  input  1  write strobe, one cycle per store.
REQ-007 rd_en_ip  input  1  read strobe, one cycle per load.
REQ-008 data_op  output  8  read data; 8'h00 when not selected, so several peripherals can be OR-combined onto the CPU data_in.
REQ-009 irq_op  output  1  registered interrupt request to the CPU irq_ip, active-high level.

Function
REQ-010 Register map (offset from BASE_ADDR): 0 CTRL, 1 FLAG, 2 COUNT, 3 RELOAD. Other addresses are ignored.
REQ-011 CTRL bit fields:
- [0] EN
- [1] ARL (auto-reload)
- [2] IE (interrupt enable)
- [5:4] PS prescale: 00 /1, 01 /4, 10 /16, 11 /64
- [7:6],[3] read as 0, writes ignored
REQ-012 FLAG[0] is OVF (overflow); FLAG[7:1] read 0; writing 1 to bit 0 clears OVF, writing 0 has no effect.
REQ-013 Writes take effect at the rising edge where wr_en_ip=1 and the address matches; the new value is visible on the next cycle.
REQ-014 data_op is combinational: register value when rd_en_ip=1 and the address matches, else 8'h00.
REQ-015 Prescaler: 6-bit counter, runs only while EN=1; tick asserted when its low log2(div) bits are all 1 (every cycle for /1); it is cleared on any CTRL write and while EN=0.
REQ-016 On tick, COUNT increments by 1 modulo 256.
REQ-017 On a tick with COUNT=8'hFF, overflow happens:
- OVF <= 1
- COUNT <= RELOAD if ARL=1, else 8'h00
- if ARL=0, EN <= 0 (one-shot)
REQ-018 irq_op <= OVF & IE on every clock, i.e. one cycle after OVF or IE changes.
REQ-019 COUNT write in the same cycle as a tick: the written value wins, no increment, no overflow.
REQ-020 Overflow in the same cycle as a FLAG write-1-clear: set wins, OVF=1.
REQ-021 CTRL write in the same cycle as a one-shot overflow: the written EN value wins.
REQ-022 RELOAD write in the same cycle as an overflow: COUNT loads the old RELOAD value.
REQ-023 Simultaneous wr_en_ip and rd_en_ip: both are honoured; the read returns the pre-write value.

Reset
REQ-024 While reset_n_ip=0 at a rising edge, state clears:
- CTRL=8'h00, OVF=0, COUNT=8'h00, RELOAD=8'h00
- prescaler=0, irq_op=0
REQ-025 Reset mid-count aborts the operation; no overflow or irq is generated from pre-reset state.
REQ-026 data_op is 8'h00 during reset unless a matching read is asserted, in which case it returns the reset values.

Verification
REQ-027 One-shot: write COUNT=8'hFD, CTRL=8'h05 (EN, IE, /1). COUNT steps FE, FF, 00. OVF=1 on the cycle COUNT reaches 00, irq_op=1 one cycle later, CTRL reads 8'h04.
REQ-028 Auto-reload with /4: RELOAD=8'hF0, COUNT=8'hFF, CTRL=8'h13. Overflow after 4 cycles loads COUNT=8'hF0. The next overflow comes 64 cycles later. irq_op stays 0 (IE=0) while FLAG reads 8'h01.
REQ-029 Clear/set collision: with OVF=1, write FLAG=8'h01 on the same edge as an overflow. Required: FLAG still reads 8'h01. A later clear with no overflow gives 8'h00, and irq_op falls one cycle later.
REQ-030 Write/tick collision: EN=1, /1, COUNT=8'hFF. Write COUNT=8'h10 on the overflow edge. Required: COUNT=8'h10, OVF=0, EN remains 1.
REQ-031 Decode and isolation with BASE_ADDR=8'h10:
- reads at 8'h0F and 8'h14 return 8'h00; writes there leave all registers unchanged
- rd_en_ip=0 at 8'h12 returns 8'h00
REQ-032 Reset mid-operation: assert reset_n_ip=0 for one cycle during /64 counting with OVF=1. Required: every register reads 00 and irq_op=0 on the next cycle, and counting does not resume.
